pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage dynamic pipeline inside sccomp_dataflow.
- Resolves four events each cycle and drives per-stage enable/flush controls:
  - external cpu_stall
  - multi-cycle MUL/DIV occupancy of EX
  - load-use hazards detected in ID
  - taken branches/jumps resolved in ID
- Owns the MUL/DIV busy counter, so the EX unit needs no timing logic of its own.

Parameters:
- MUL_CYCLES, 4, total EX occupancy of a multiply (must be >= 2).
- DIV_CYCLES, 33, total EX occupancy of a divide (must be >= 2).
- CNT_W, 6, width of the busy counter (must hold max(MUL_CYCLES, DIV_CYCLES)-1).

Ports:
- clk  in  1  pipeline clock, posedge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_stall  in  1  external freeze request.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_use_rs  in  1  the ID instruction reads rs.
- id_use_rt  in  1  the ID instruction reads rt.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_mem_read  in  1  the EX instruction is a load.
- id_branch_taken  in  1  branch/jump in ID resolved taken.
- ex_md_start  in  1  the EX instruction is MUL/DIV.
- ex_md_is_div  in  1  1 = divide, 0 = multiply.
- pc_en  out  1  PC register write enable.
- if_id_en  out  1  IF/ID latch enable.
- if_id_flush  out  1  IF/ID loads a bubble.
- id_ex_en  out  1  ID/EX latch enable.
- id_ex_flush  out  1  ID/EX loads a bubble.
- ex_mem_en  out  1  EX/MEM latch enable.
- ex_mem_flush  out  1  EX/MEM loads a bubble.
- mem_wb_en  out  1  MEM/WB latch enable.
- md_busy  out  1  MUL/DIV occupying EX.
- md_done  out  1  one-cycle pulse; MUL/DIV result valid this cycle.

Behaviour:
- State machine:
  - States: RST_HOLD, RUN, MD.
  - Registers: state and md_cnt[CNT_W-1:0]. All outputs are combinational from these registers plus the inputs.
- Reset:
  - reset_n low → state=RST_HOLD, md_cnt=0.
  - In RST_HOLD all enables=0, all flushes=0, md_busy=0, md_done=0.
  - The first posedge with reset_n high moves RST_HOLD→RUN.
  - Reset asserted mid-MD aborts the operation immediately; md_done is never produced for it.
- Priority, highest first:
  1. RST_HOLD
  2. cpu_stall
  3. MD freeze
  4. load-use
  5. branch flush
  6. normal advance
- cpu_stall=1:
  - All enables=0, all flushes=0.
  - md_cnt holds and state holds.
- MD freeze:
  - Active when (state==RUN and ex_md_start) or (state==MD and md_cnt!=0).
  - pc_en, if_id_en, id_ex_en = 0.
  - ex_mem_en=1 with ex_mem_flush=1; mem_wb_en=1.
  - md_busy=1.
- RUN→MD transition:
  - On the freeze cycle in RUN, md_cnt loads (ex_md_is_div ? DIV_CYCLES : MULs MUL_CYCLES) - 1.
  - In MD, md_cnt decrements by 1 each non-stalled cycle.
  - At md_cnt==0 in MD: md_done=1, md_busy=0, normal advance, state→RUN.
  - Start-to-done latency is exactly N cycles, with N freeze cycles.
  - ex_md_start is ignored while state==MD.
- Load-use:
  - Condition: ex_mem_read && ex_rd!=0 && ((id_use_rs && id_rs==ex_rd) || (id_use_rt && id_rt==ex_rd)).
  - Response: pc_en=0, if_id_en=0, id_ex_en=1 with id_ex_flush=1, later stages enabled.
  - id_branch_taken is ignored in this cycle; the branch re-resolves next cycle.
- Branch flush:
  - Condition: id_branch_taken with no higher-priority event.
  - Response: all enables=1, if_id_flush=1.
- Normal advance:
  - All enables=1, all flushes=0.
- Register $0 never produces a load-use hazard.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - Adds 32-bit outputs stall_cycles, md_cycles, lu_bubbles and br_flushes, all reset to 0.
  - Each increments by 1 in a cycle where cpu_stall, MD freeze, load-use or branch flush respectively is the winning condition.
  - Counters wrap modulo 2^32.
- Undefined:
  - The ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - state encoding (RST_HOLD=2'd0, RUN=2'd1, MD=2'd2)
  - REG_ZERO=5'd0
  - the default MUL_CYCLES/DIV_CYCLES constants
- One sub-module, md_busy_timer: md_cnt load/decrement/hold, with outputs md_busy and md_done.
- Priority logic stays in the top level.

Test Plan:
- Release reset_n at cycle 0 → cycle 0 has all enables 0; cycle 1 has all enables 1 and flushes 0.
- lw $8 in EX (ex_rd=8, ex_mem_read=1) with ID reading rs=8 → exactly one cycle of pc_en=0, if_id_en=0, id_ex_flush=1. Same test with ex_rd=0 → no stall.
- ex_md_start=1 with ex_md_is_div=1 → 33 consecutive cycles of pc_en=0 and ex_mem_flush=1, then md_done=1 on the 34th cycle with full advance. With ex_md_is_div=0 → 4 freeze cycles, done on the 5th.
- cpu_stall=1 for 3 cycles in the middle of a divide → md_cnt frozen and all enables 0; md_done is delayed by exactly 3 cycles (done on cycle 37).
- Load-use and id_branch_taken in the same cycle → load-use response only. The next cycle with id_branch_taken=1 → if_id_flush=1 for one cycle.
- reset_n pulsed low during MD with md_cnt=10 → state RST_HOLD; md_done never asserts; after release, RUN with md_cnt=0.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipe_pkg
// Brief   : Shared state encoding and constants for the pipeline hazard control
// Rev     : 1.0
// ============================================================================
package pipe_pkg;

    typedef enum logic [1:0] {
        RST_HOLD = 2'd0,
        RUN      = 2'd1,
        MD       = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO       = 5'd0;
    localparam int         MUL_CYCLES_DEF = 4;
    localparam int         DIV_CYCLES_DEF = 33;

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : pipe_hazard_ctrl_if
// Brief   : Hazard inputs and per-stage enable/flush controls of the pipeline
// Rev     : 1.0
// ============================================================================
interface pipe_hazard_ctrl_if;
    logic       cpu_stall;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic [4:0] ex_rd;
    logic       ex_mem_read;
    logic       id_branch_taken;
    logic       ex_md_start;
    logic       ex_md_is_div;
    logic       pc_en;
    logic       if_id_en;
    logic       if_id_flush;
    logic       id_ex_en;
    logic       id_ex_flush;
    logic       ex_mem_en;
    logic       ex_mem_flush;
    logic       mem_wb_en;
    logic       md_busy;
    logic       md_done;

    modport master (
        output cpu_stall, id_rs, id_rt, id_use_rs, id_use_rt, ex_rd, ex_mem_read,
               id_branch_taken, ex_md_start, ex_md_is_div,
        input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
               ex_mem_flush, mem_wb_en, md_busy, md_done
    );

    modport slave (
        input  cpu_stall, id_rs, id_rt, id_use_rs, id_use_rt, ex_rd, ex_mem_read,
               id_branch_taken, ex_md_start, ex_md_is_div,
        output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
               ex_mem_flush, mem_wb_en, md_busy, md_done
    );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_md_busy_timer.sv
`default_nettype none
// ============================================================================
// Module  : md_busy_timer
// Brief   : MUL/DIV occupancy counter of the EX stage (busy / done pulse)
// Rev     : 1.0
// ============================================================================
module md_busy_timer
    import pipe_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int CNT_W      = 6
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_run,
    input  logic in_md,
    input  logic start,
    input  logic stall,
    input  logic is_div,
    output logic md_busy,
    output logic md_done
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    logic [CNT_W-1:0] md_cnt;
    logic             cnt_zero;

    assign cnt_zero = (md_cnt == '0);

    // The start cycle itself is the first freeze cycle, hence the N-1 load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            md_cnt <= '0;
        end else if (!stall) begin
            if (in_run && start) begin
                md_cnt <= is_div ? DIV_LOAD : MUL_LOAD;
            end else if (in_md && !cnt_zero) begin
                md_cnt <= md_cnt - CNT_W'(1);
            end
        end
    end

    assign md_busy = (in_run && start) || (in_md && !cnt_zero);
    assign md_done = in_md && cnt_zero && !stall;

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipe_hazard_ctrl
// Brief   : Stall/flush sequencer of the 5-stage pipeline; optional
//           performance counters enabled by HAZARD_PERF_CNT_EN
// Rev     : 1.0
// ============================================================================
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int CNT_W      = 6
) (
    input  logic                 clk,
    input  logic                 reset_n,
    pipe_hazard_ctrl_if.slave    hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]          stall_cycles,
    output logic [31:0]          md_cycles,
    output logic [31:0]          lu_bubbles,
    output logic [31:0]          br_flushes
`endif
);

    state_t state;
    state_t state_nxt;
    logic   in_run;
    logic   in_md;
    logic   md_busy;
    logic   md_done;
    logic   load_use;
    logic   win_stall;
    logic   win_md;
    logic   win_lu;
    logic   win_br;

    assign in_run = (state == RUN);
    assign in_md  = (state == MD);

    md_busy_timer #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_md_busy_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .in_run  (in_run),
        .in_md   (in_md),
        .start   (hz.ex_md_start),
        .stall   (hz.cpu_stall),
        .is_div  (hz.ex_md_is_div),
        .md_busy (md_busy),
        .md_done (md_done)
    );

    assign load_use = hz.ex_mem_read && (hz.ex_rd != REG_ZERO) &&
                      ((hz.id_use_rs && (hz.id_rs == hz.ex_rd)) ||
                       (hz.id_use_rt && (hz.id_rt == hz.ex_rd)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RST_HOLD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        win_stall       = 1'b0;
        win_md          = 1'b0;
        win_lu          = 1'b0;
        win_br          = 1'b0;
        hz.pc_en        = 1'b0;
        hz.if_id_en     = 1'b0;
        hz.if_id_flush  = 1'b0;
        hz.id_ex_en     = 1'b0;
        hz.id_ex_flush  = 1'b0;
        hz.ex_mem_en    = 1'b0;
        hz.ex_mem_flush = 1'b0;
        hz.mem_wb_en    = 1'b0;
        hz.md_busy      = md_busy;
        hz.md_done      = md_done;
        if (state == RST_HOLD) begin
            state_nxt = RUN;
        end else if (hz.cpu_stall) begin
            win_stall = 1'b1;
        end else if (md_busy) begin
            // Drain the older instructions while a bubble follows the MUL/DIV.
            win_md          = 1'b1;
            hz.ex_mem_en    = 1'b1;
            hz.ex_mem_flush = 1'b1;
            hz.mem_wb_en    = 1'b1;
            if (in_run) begin
                state_nxt = MD;
            end
        end else begin
            if (in_md) begin
                state_nxt = RUN;
            end
            hz.id_ex_en  = 1'b1;
            hz.ex_mem_en = 1'b1;
            hz.mem_wb_en = 1'b1;
            if (load_use) begin
                win_lu         = 1'b1;
                hz.id_ex_flush = 1'b1;
            end else begin
                hz.pc_en    = 1'b1;
                hz.if_id_en = 1'b1;
                if (hz.id_branch_taken) begin
                    win_br         = 1'b1;
                    hz.if_id_flush = 1'b1;
                end
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles <= '0;
            md_cycles    <= '0;
            lu_bubbles   <= '0;
            br_flushes   <= '0;
        end else begin
            stall_cycles <= stall_cycles + {31'd0, win_stall};
            md_cycles    <= md_cycles    + {31'd0, win_md};
            lu_bubbles   <= lu_bubbles   + {31'd0, win_lu};
            br_flushes   <= br_flushes   + {31'd0, win_br};
        end
    end
`else
    logic unused_win;
    assign unused_win = win_stall ^ win_md ^ win_lu ^ win_br;
`endif

endmodule
`default_nettype wire
